// File: rtl/orb_spi_pkg.sv
// orb_spi_pkg: shared widths and defaults for the SPI trace transmit/receive path
package orb_spi_pkg;
  localparam int SPI_PKT_W = 128;
  localparam int SPI_RX_W = 32;
  localparam int UNDERRUN_CNT_W = 16;
  typedef logic [SPI_PKT_W-1:0] spi_pkt_t;
  localparam spi_pkt_t IDLE_PATTERN_DEF = '0;
endpackage

// File: rtl/spi_tx_feeder_if.sv
// spi_tx_feeder_if: valid/ready packet handshake from the trace packet producer
interface spi_tx_feeder_if;
  import orb_spi_pkg::*;
  spi_pkt_t in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/spi_tx_feeder_toggle_sync.sv
// toggle_sync: synchronises a request toggle and emits one req pulse per toggle
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic req
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic prev_q;
  logic primed_q;
  // The far-side toggle has no known reset value, so the first settled level is absorbed rather than treated as an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      primed_q <= primed_q | fill_q[SYNC_STAGES-1];
    end
  end
  assign req = primed_q && (sync_q[SYNC_STAGES-1] ^ prev_q);
endmodule

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: buffers trace packets and presents one per TxGetNext toggle to the SPI slave
module spi_tx_feeder
  import orb_spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter spi_pkt_t IDLE_PATTERN = IDLE_PATTERN_DEF
) (
  input  logic clk,
  input  logic rst,
  spi_tx_feeder_if.slave up,
  input  logic flush,
  input  logic TxGetNext,
  output spi_pkt_t Tx_packet,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  spi_pkt_t mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic req, push, pop, empty, full;
  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .tgl(TxGetNext),
    .req(req)
  );
  assign empty = fifo_level == '0;
  assign full = fifo_level == (AW+1)'(DEPTH);
  assign up.in_ready = !full && !flush;
  assign push = up.in_valid && up.in_ready;
  assign pop = req && !empty;
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= up.in_data;
  end
  // A request coinciding with flush is served from the pre-flush head before the queue is cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Tx_packet <= IDLE_PATTERN;
      underrun_cnt <= '0;
      rd_q <= '0;
      wr_q <= '0;
      fifo_level <= '0;
    end else begin
      if (req) Tx_packet <= empty ? IDLE_PATTERN : mem[rd_q];
      if (req && empty && underrun_cnt != '1) underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
      rd_q <= flush ? '0 : rd_q + AW'(pop);
      wr_q <= flush ? '0 : wr_q + AW'(push);
      fifo_level <= flush ? '0 : fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
